data_mem_ctrl: RTL and testbench

Data-memory stage directly downstream of the 64-bit ALU. It takes the ALU result (BusW) as a byte address, plus the register-file store value, and performs one doubleword load or store with a fixed, parameterised access latency. A Req/Ack handshake lets the multi-cycle datapath controller stall until each access completes. Addressing is doubleword-aligned; misaligned accesses are flagged rather than performed.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 34 +++
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: FSM encoding, data width,
// doubleword offset width and misalignment mask.
package dmem_pkg;

  localparam int DATA_W    = 64;
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFFSET_W  = 3;

  localparam logic [OFFSET_W-1:0] MISALIGN_MASK = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } dmemState_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 doubleword storage: synchronous byte-enabled write, registered read.
// Only the read register is reset; the array contents are left as they are.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [IDX_W-1:0]     idx,
  input  logic [DATA_W-1:0]    wrData,
  input  logic [NUM_LANES-1:0] byteEn,
  output logic [DATA_W-1:0]    rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (byteEn[i]) mem[idx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)   rdData <= '0;
    else if (re) rdData <= mem[idx];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency doubleword load/store stage with Req/Ack handshake.
// Optional byte-lane store strobes are enabled with `define DMEM_BYTE_STRB_EN.
//
// state  | meaning
// S_IDLE | no access in flight, ready to accept
// S_WAIT | access captured, latency counter running
// S_DONE | commit done, Ack for one cycle, may accept the next access
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
`ifdef DMEM_BYTE_STRB_EN
  input  logic [7:0]        WriteStrobe,
`endif
  output logic [DATA_W-1:0] ReadData,
  output logic              Busy,
  output logic              Ack,
  output logic              Err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = IDX_W + OFFSET_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmemState_t state, nextState;

  logic [CNT_W-1:0]     cnt;
  logic                 opWriteQ;
  logic [ADDR_W-1:0]    addrQ;
  logic [DATA_W-1:0]    dataQ;
  logic [NUM_LANES-1:0] strbQ;
  logic                 errIllegal;

  logic                 canAccept, legalOp, accept, illegal, inFlight;
  logic                 commit, effWrite, effMis, memWe, memRe;
  logic [ADDR_W-1:0]    effAddr;
  logic [DATA_W-1:0]    effData;
  logic [NUM_LANES-1:0] effStrb, reqStrb;
  logic                 unusedAddrHi;

`ifdef DMEM_BYTE_STRB_EN
  assign reqStrb = WriteStrobe;
`else
  assign reqStrb = '1;
`endif

  assign unusedAddrHi = ^Address[DATA_W-1:ADDR_W];

  assign canAccept = (state != S_WAIT);
  assign legalOp   = MemRead ^ MemWrite;
  assign accept    = canAccept & Req & legalOp;
  assign illegal   = canAccept & Req & ~legalOp;
  assign inFlight  = (state == S_WAIT);

  // With LATENCY=1 the commit happens on the accept edge, so it must use the live inputs.
  assign effWrite = inFlight ? opWriteQ : MemWrite;
  assign effAddr  = inFlight ? addrQ    : Address[ADDR_W-1:0];
  assign effData  = inFlight ? dataQ    : WriteData;
  assign effStrb  = inFlight ? strbQ    : reqStrb;
  assign effMis   = |(effAddr[OFFSET_W-1:0] & MISALIGN_MASK);

  always_comb begin
    nextState = state;
    unique case (state)
      S_WAIT:  if (cnt == CNT_W'(1)) nextState = S_DONE;
      default: begin
        if (accept) nextState = (LATENCY == 1) ? S_DONE : S_WAIT;
        else        nextState = S_IDLE;
      end
    endcase
  end

  assign commit = (nextState == S_DONE) & ~Reset;
  assign memWe  = commit & effWrite & ~effMis;
  assign memRe  = commit & ~effWrite & ~effMis;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      errIllegal <= 1'b0;
      opWriteQ   <= 1'b0;
      addrQ      <= '0;
      dataQ      <= '0;
      strbQ      <= '0;
    end else begin
      state      <= nextState;
      errIllegal <= illegal;
      if (accept) begin
        cnt      <= CNT_W'(LATENCY - 1);
        opWriteQ <= MemWrite;
        addrQ    <= Address[ADDR_W-1:0];
        dataQ    <= WriteData;
        strbQ    <= reqStrb;
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign Ack  = (state == S_DONE);
  assign Busy = (state != S_IDLE);
  assign Err  = errIllegal | (Ack & |(addrQ[OFFSET_W-1:0] & MISALIGN_MASK));

  dmem_array #(
    .DEPTH (DEPTH)
  ) uArray (
    .Clk    (Clk),
    .Reset  (Reset),
    .we     (memWe),
    .re     (memRe),
    .idx    (effAddr[ADDR_W-1:OFFSET_W]),
    .wrData (effData),
    .byteEn (effStrb),
    .rdData (ReadData)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl against a doubleword-array reference model.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        Clk = 1'b0;
  logic        Reset, Req, MemRead, MemWrite;
  logic [63:0] Address, WriteData, ReadData;
  logic        Busy, Ack, Err;
`ifdef DMEM_BYTE_STRB_EN
  logic [7:0]  WriteStrobe;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [63:0] refMem [DEPTH];
  logic [63:0] expRd;

  always #5 Clk = ~Clk;

  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req       (Req),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
`ifdef DMEM_BYTE_STRB_EN
    .WriteStrobe (WriteStrobe),
`endif
    .ReadData  (ReadData),
    .Busy      (Busy),
    .Ack       (Ack),
    .Err       (Err)
  );

  function automatic int idxOf(input logic [63:0] a);
    return int'((a / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic issue(input bit wr, input logic [63:0] a, input logic [63:0] d);
    Req = 1'b1; MemRead = !wr; MemWrite = wr; Address = a; WriteData = d;
`ifdef DMEM_BYTE_STRB_EN
    WriteStrobe = 8'hFF;
`endif
  endtask

  task automatic idle(input int n);
    Req = 1'b0;
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // mode 0: drop Req after accept; 1: also scramble other inputs; 2: Req=1 store to 0x30 during WAIT
  task automatic waitAck(input int mode, output int lat, output int busyCnt,
                         output logic e, output logic [63:0] rd);
    @(posedge Clk); #1;
    lat = 1; busyCnt = 0;
    for (int g = 0; g < 32; g++) begin
      if (Busy) busyCnt++;
      if (Ack) break;
      if (lat > 20) begin
        tests++; fails++;
        $display("FAIL ack_timeout: no Ack within %0d cycles, required within %0d", lat, LAT);
        break;
      end
      if (mode == 2) issue(1'b1, 64'h30, rand64());
      else begin
        Req = 1'b0;
        if (mode == 1) begin
          Address = rand64(); WriteData = rand64();
          MemWrite = 1'($urandom_range(0, 1)); MemRead = !MemWrite;
        end
      end
      @(posedge Clk); #1; lat++;
    end
    e = Err; rd = ReadData;
    Req = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; WriteData = '0;
`ifdef DMEM_BYTE_STRB_EN
    WriteStrobe = 8'hFF;
`endif
    repeat (3) @(posedge Clk); #1;
    tests++; if (ReadData !== 64'h0) begin fails++; $display("FAIL reset_rd: got %h want 0", ReadData); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", Busy); end
    tests++; if (Ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", Ack); end
    tests++; if (Err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", Err); end
    Reset = 1'b0; expRd = '0;
    @(posedge Clk); #1;
  endtask

  task automatic fill_all();
    int l, b; logic e; logic [63:0] rd, d;
    for (int i = 0; i < DEPTH; i++) begin
      d = rand64();
      issue(1'b1, 64'(i * 8), d);
      waitAck(0, l, b, e, rd);
      refMem[i] = d;
    end
    idle(1);
  endtask

  task automatic test_store_load();
    int l, b; logic e; logic [63:0] rd;
    issue(1'b1, 64'h10, 64'hDEADBEEFCAFEF00D);
    waitAck(0, l, b, e, rd);
    refMem[2] = 64'hDEADBEEFCAFEF00D;
    tests++; if (l != LAT) begin fails++; $display("FAIL st_latency: got %0d want %0d", l, LAT); end
    tests++; if (b != LAT) begin fails++; $display("FAIL st_busy_cycles: got %0d want %0d", b, LAT); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL st_err: got %b want 0", e); end
    idle(1);
    issue(1'b0, 64'h10, 64'h0);
    waitAck(0, l, b, e, rd);
    expRd = refMem[2];
    tests++; if (rd !== expRd) begin fails++; $display("FAIL ld_data: got %h want %h", rd, expRd); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL ld_err: got %b want 0", e); end
    tests++; if (l != LAT) begin fails++; $display("FAIL ld_latency: got %0d want %0d", l, LAT); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int l, b; logic e; logic [63:0] rd, v;
    v = rand64();
    issue(1'b1, 64'h18, v);
    waitAck(0, l, b, e, rd);
    refMem[3] = v;
    issue(1'b0, 64'h18, 64'h0);
    waitAck(1, l, b, e, rd);
    expRd = refMem[3];
    tests++; if (l != LAT) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", l, LAT); end
    tests++; if (b != LAT) begin fails++; $display("FAIL b2b_busy: got %0d want %0d", b, LAT); end
    tests++; if (rd !== expRd) begin fails++; $display("FAIL b2b_data: got %h want %h", rd, expRd); end
    idle(1);
    issue(1'b0, 64'h10, 64'h0);
    waitAck(0, l, b, e, rd);
    expRd = refMem[2];
    tests++; if (rd !== expRd) begin fails++; $display("FAIL b2b_scramble: got %h want %h", rd, expRd); end
    idle(1);
  endtask

  task automatic test_misaligned();
    int l, b; logic e; logic [63:0] rd;
    issue(1'b1, 64'h13, rand64());
    waitAck(0, l, b, e, rd);
    tests++; if (l != LAT) begin fails++; $display("FAIL mis_st_latency: got %0d want %0d", l, LAT); end
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL mis_st_err: got %b want 1", e); end
    idle(1);
    issue(1'b0, 64'h15, 64'h0);
    waitAck(0, l, b, e, rd);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL mis_ld_err: got %b want 1", e); end
    tests++; if (rd !== expRd) begin fails++; $display("FAIL mis_ld_hold: got %h want %h", rd, expRd); end
    idle(1);
    issue(1'b0, 64'h10, 64'h0);
    waitAck(0, l, b, e, rd);
    expRd = refMem[2];
    tests++; if (rd !== expRd) begin fails++; $display("FAIL mis_no_write: got %h want %h", rd, expRd); end
    idle(1);
  endtask

  task automatic test_illegal();
    int l, b, acks; logic e; logic [63:0] rd, v;
    for (int k = 0; k < 2; k++) begin
      Req = 1'b1; MemRead = (k == 0); MemWrite = (k == 0); Address = 64'h8;
      @(posedge Clk); #1; Req = 1'b0;
      tests++; if (Err !== 1'b1) begin fails++; $display("FAIL ill_err%0d: got %b want 1", k, Err); end
      tests++; if (Ack !== 1'b0) begin fails++; $display("FAIL ill_ack%0d: got %b want 0", k, Ack); end
      tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL ill_busy%0d: got %b want 0", k, Busy); end
      @(posedge Clk); #1;
      tests++; if (Err !== 1'b0) begin fails++; $display("FAIL ill_pulse%0d: got %b want 0", k, Err); end
    end
    v = rand64();
    issue(1'b1, 64'h28, v);
    waitAck(2, l, b, e, rd);
    refMem[5] = v;
    tests++; if (l != LAT) begin fails++; $display("FAIL wait_req_latency: got %0d want %0d", l, LAT); end
    acks = 0;
    repeat (5) begin @(posedge Clk); #1; if (Ack) acks++; end
    tests++; if (acks != 0) begin fails++; $display("FAIL wait_req_acks: got %0d want 0", acks); end
    issue(1'b0, 64'h30, 64'h0);
    waitAck(0, l, b, e, rd);
    expRd = refMem[6];
    tests++; if (rd !== expRd) begin fails++; $display("FAIL wait_req_nowrite: got %h want %h", rd, expRd); end
    idle(1);
  endtask

  task automatic test_reset_abort();
    int l, b, acks; logic e; logic [63:0] rd;
    issue(1'b1, 64'h20, rand64());
    @(posedge Clk); #1;
    Req = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; expRd = '0;
    tests++; if (Ack !== 1'b0) begin fails++; $display("FAIL abort_ack: got %b want 0", Ack); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", Busy); end
    tests++; if (ReadData !== 64'h0) begin fails++; $display("FAIL abort_rd: got %h want 0", ReadData); end
    acks = 0;
    repeat (4) begin @(posedge Clk); #1; if (Ack) acks++; end
    tests++; if (acks != 0) begin fails++; $display("FAIL abort_late_ack: got %0d want 0", acks); end
    issue(1'b0, 64'h20, 64'h0);
    waitAck(0, l, b, e, rd);
    expRd = refMem[4];
    tests++; if (rd !== expRd) begin fails++; $display("FAIL abort_nowrite: got %h want %h", rd, expRd); end
    idle(1);
  endtask

  task automatic test_wrap();
    int l, b; logic e; logic [63:0] rd, v;
    v = rand64();
    issue(1'b1, 64'h200, v);
    waitAck(0, l, b, e, rd);
    refMem[idxOf(64'h200)] = v;
    idle(1);
    issue(1'b0, 64'h0, 64'h0);
    waitAck(0, l, b, e, rd);
    expRd = refMem[0];
    tests++; if (rd !== expRd) begin fails++; $display("FAIL wrap_data: got %h want %h", rd, expRd); end
    idle(1);
  endtask

`ifdef DMEM_BYTE_STRB_EN
  task automatic test_strobe();
    int l, b; logic e; logic [63:0] rd, want;
    want = {refMem[8][63:32], 32'hFFFF_FFFF};
    issue(1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF); WriteStrobe = 8'h0F;
    waitAck(0, l, b, e, rd);
    refMem[8] = want;
    issue(1'b1, 64'h40, 64'h0); WriteStrobe = 8'h00;
    waitAck(0, l, b, e, rd);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL strb_zero_err: got %b want 0", e); end
    idle(1);
    issue(1'b0, 64'h40, 64'h0);
    waitAck(0, l, b, e, rd);
    expRd = refMem[8];
    tests++; if (rd !== expRd) begin fails++; $display("FAIL strb_data: got %h want %h", rd, expRd); end
    idle(1);
  endtask
`endif

  task automatic test_random();
    int l, b, i; bit wr, mis; logic e; logic [63:0] rd, a, d;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = rand64();
      if ($urandom_range(0, 4) == 0) a[2:0] = 3'($urandom_range(1, 7));
      else                           a[2:0] = 3'b000;
      d   = rand64();
      mis = (a % 64'd8) != 0;
      i   = idxOf(a);
      issue(wr, a, d);
      waitAck(0, l, b, e, rd);
      if (!mis) begin
        if (wr) refMem[i] = d;
        else    expRd = refMem[i];
      end
      tests++; if (l != LAT) begin fails++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, l, LAT); end
      tests++; if (e !== mis) begin fails++; $display("FAIL rnd%0d_err: got %b want %b", n, e, mis); end
      tests++; if (rd !== expRd) begin fails++; $display("FAIL rnd%0d_data: got %h want %h", n, rd, expRd); end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    fill_all();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_illegal();
    test_reset_abort();
    test_wrap();
`ifdef DMEM_BYTE_STRB_EN
    test_strobe();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
